// File: rtl/onewire_seq.sv
// 1-Wire transaction sequencer: reset pulse, presence sample, then up to four
// command bytes handed one at a time to an external byte-write engine.
module onewire_seq #(
  parameter int CLKS_PER_US        = 27,
  parameter int RESET_LOW_US       = 480,
  parameter int PRESENCE_SAMPLE_US = 70,
  parameter int RECOVER_US         = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cmd,
  input  logic [2:0]  cmd_len,
  input  logic        dq_in,
  input  logic        wr_done,
  output logic        wr_enable,
  output logic [7:0]  wr_byte,
  output logic        rst_drive_low,
  output logic        busy,
  output logic        done,
  output logic        presence
);
  localparam int T_RST = RESET_LOW_US * CLKS_PER_US;
  localparam int T_SMP = PRESENCE_SAMPLE_US * CLKS_PER_US;
  localparam int T_REC = RECOVER_US * CLKS_PER_US;
  localparam int T_MAX = (T_RST > T_REC) ? ((T_RST > T_SMP) ? T_RST : T_SMP)
                                         : ((T_REC > T_SMP) ? T_REC : T_SMP);
  localparam int CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, WR_BYTE, WR_GAP, FINISH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n, len_q, len_n;
  logic [31:0]   cmd_q, cmd_n;
  logic          pres_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    len_n   = len_q;
    cmd_n   = cmd_q;
    pres_n  = presence;
    case (state)
      IDLE: if (start) begin
        cmd_n   = cmd;
        len_n   = (cmd_len > 3'd4) ? 3'd4 : cmd_len;
        pres_n  = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
        state_n = RST_LOW;
      end
      RST_LOW: if (cnt == CW'(T_RST - 1)) begin
        cnt_n   = '0;
        state_n = RST_WAIT;
      end else cnt_n = cnt + 1'b1;
      RST_WAIT: begin
        if (cnt == CW'(T_SMP)) pres_n = ~dq_in;
        // decide on pres_n so a sample on the final cycle is still honoured
        if (cnt == CW'(T_REC - 1)) begin
          cnt_n   = '0;
          state_n = (pres_n && len_q != 3'd0) ? WR_BYTE : FINISH;
        end else cnt_n = cnt + 1'b1;
      end
      WR_BYTE: if (wr_done) begin
        idx_n   = idx + 3'd1;
        state_n = WR_GAP;
      end
      WR_GAP:  state_n = (idx < len_q) ? WR_BYTE : FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered decodes of the next state so they align with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      len_q         <= '0;
      cmd_q         <= '0;
      presence      <= 1'b0;
      wr_enable     <= 1'b0;
      wr_byte       <= '0;
      rst_drive_low <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      len_q         <= len_n;
      cmd_q         <= cmd_n;
      presence      <= pres_n;
      wr_enable     <= (state_n == WR_BYTE);
      rst_drive_low <= (state_n == RST_LOW);
      busy          <= (state_n inside {RST_LOW, RST_WAIT, WR_BYTE, WR_GAP});
      done          <= (state_n == FINISH);
      if (state_n == WR_BYTE) wr_byte <= cmd_q[{idx_n[1:0], 3'b000} +: 8];
    end
  end
endmodule

// File: doc/onewire_seq.md
ONEWIRE_SEQ -- requirements
Module: onewire_seq

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 27, meaning clock cycles per microsecond.
REQ-002 SHALL have parameter RESET_LOW_US, default 480, meaning reset pulse low time.
REQ-003 SHALL have parameter PRESENCE_SAMPLE_US, default 70, meaning presence sample point after release.
REQ-004 SHALL have parameter RECOVER_US, default 480, meaning total time from release to end of reset slot.
REQ-005 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: start  in  1  request a transaction (level, sampled in IDLE).
REQ-008 SHALL have ports: cmd  in  32  up to four command bytes, byte 0 = cmd[7:0] sent first.
REQ-009 SHALL have ports: cmd_len  in  3  number of bytes to write (0..4; 5..7 treated as 4).
REQ-010 SHALL have ports: dq_in  in  1  bus level, already synchronized to clk.
REQ-011 SHALL have ports: wr_done  in  1  byte-write engine finished current byte.
REQ-012 SHALL have ports: wr_enable  out  1  enable to byte-write engine, held until wr_done.
REQ-013 SHALL have ports: wr_byte  out  8  byte presented to write engine.
REQ-014 SHALL have ports: rst_drive_low  out  1  pull bus low for reset pulse.
REQ-015 SHALL have ports: busy  out  1  transaction in progress.
REQ-016 SHALL have ports: done  out  1  one-cycle pulse at transaction end.
REQ-017 SHALL have ports: presence  out  1  presence result of last transaction, valid from done until next start.

Function
REQ-018 SHALL implement states IDLE, RST_LOW, RST_WAIT, WR_BYTE, WR_GAP, FINISH.
REQ-019 In IDLE with start=1: latch cmd, clamp cmd_len to 4 and latch, clear presence, clear counter, go RST_LOW; busy=1 from the next cycle.
REQ-020 RST_LOW: rst_drive_low=1 for exactly RESET_LOW_US*CLKS_PER_US cycles, then counter cleared, go RST_WAIT.
REQ-021 RST_WAIT: rst_drive_low=0; on the cycle counter == PRESENCE_SAMPLE_US*CLKS_PER_US, presence <= ~dq_in (only sample taken).
REQ-022 RST_WAIT lasts exactly RECOVER_US*CLKS_PER_US cycles; exit to WR_BYTE if presence=1 and latched length >0, else FINISH.
REQ-023 WR_BYTE: wr_enable=1, wr_byte = latched byte[idx]; stays until wr_done=1.
REQ-024 On wr_done=1 in WR_BYTE: go WR_GAP, wr_enable=0 next cycle, idx increments.
REQ-025 WR_GAP: wr_enable=0 for exactly one cycle (lets engine clear); then WR_BYTE if idx < length, else FINISH.
REQ-026 FINISH: done=1 for one cycle, busy=0 same cycle, return to IDLE; start in that cycle is ignored.
REQ-027 start while busy SHALL be ignored; cmd/cmd_len changes after acceptance SHALL not affect the transaction.
REQ-028 wr_done outside WR_BYTE SHALL be ignored.
REQ-029 rst_drive_low and wr_enable SHALL never be 1 in the same cycle; all outputs registered.
REQ-030 Counter SHALL be wide enough for the largest of the three intervals; no wrap during any state.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, counter=0, idx=0, and all outputs (wr_enable, wr_byte, rst_drive_low, busy, done, presence) to 0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no done pulse; first start after release begins a fresh reset pulse.

Verification
REQ-033 start, cmd_len=2, cmd=0x0000_44CC, dq_in low from 20 us to 140 us after release, engine wr_done 10 cycles after each enable -> rst_drive_low high 12960 cycles, presence=1, bytes 0xCC then 0x44, one done pulse.
REQ-034 start, cmd_len=1, dq_in held high -> presence=0, wr_enable never asserted, done exactly 12960+12960+1 cycles after start accepted (+/-1 per state entry).
REQ-035 start, cmd_len=0, device present -> reset slot only, done pulse, wr_enable never high.
REQ-036 cmd_len=7, cmd=0x11223344 -> exactly four bytes 0x44,0x33,0x22,0x11; WR_GAP single-cycle wr_enable low between each.
REQ-037 start re-pulsed during RST_WAIT and during WR_BYTE -> no restart, single done.
REQ-038 rst_n low during second WR_BYTE -> outputs zero immediately, no done; new start yields full normal transaction.
